ca_row_sequencer: RTL and testbench
===================================

// Module: ca_row_sequencer
// PURPOSE
//  Sequential 1-D elementary cellular automaton engine: holds a WIDTH-cell row, emits
//  NGEN successive generations over a valid/ready stream, one row per accepted beat.
//  Adds programmable boundary modes, latched rule and seed loading.
//  Sits between control logic and the VGA row buffer (80 cells per scanline row).
// PARAMETERS
//  WIDTH  80  cells per row
//  CW     16  width of generation count / counter
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  seed_load  in   1      load seed into row register (IDLE only)
//  seed       in   WIDTH  initial row
//  rule       in   8      Wolfram rule; sampled on accepted start
//  bmode      in   2      boundary: 00 wrap, 01 zero, 10 one, 11 = wrap
//  start      in   1      begin run (IDLE only)
//  ngen       in   CW     rows to emit incl. seed row; sampled with start
//  row_data   out  WIDTH  current generation
//  row_valid  out  1      row_data valid
//  row_ready  in   1      downstream accepts row
//  busy       out  1      high in RUN
//  done       out  1      one-cycle pulse at end of run
//  gen_count  out  CW     rows accepted so far in current run
// BEHAVIOUR
//  Reset: state=IDLE; row, rule_q, bmode_q, ngen_q, gen_count=0; row_valid, busy, done=0.
//  Reset mid-run aborts immediately; no further beats, no done pulse.
//  Cell update: next[i] = rule_q[{L,row[i],R}], L = left = row[i-1], R = row[i+1].
//   i=0 left and i=WIDTH-1 right are boundary cells: wrap -> row[WIDTH-1]/row[0];
//   zero -> 0; one -> 1. bmode sampled with start (bmode_q), constant during run.
//  States: IDLE, RUN, DONE.
//   IDLE: seed_load=1 -> row<=seed. start=1 -> latch rule, bmode, ngen; gen_count<=0;
//    if ngen==0 -> DONE, else -> RUN. seed_load and start same cycle: seed loaded, run
//    starts from new seed.
//   RUN: row_valid=1, busy=1. Beat = row_valid&row_ready: row<=next(row),
//    gen_count<=gen_count+1; if gen_count==ngen_q-1 -> DONE. Without beat row_data
//    and row_valid held stable (no combinational ready->valid path).
//   DONE: done=1 for exactly one cycle, row_valid=0, -> IDLE. Row keeps next
//    generation after last emitted, so a new start continues the sequence.
//  start and seed_load ignored outside IDLE; rule/bmode/ngen input changes mid-run
//   have no effect. First beat of a run = seed row (generation 0). Latency start->first
//   row_valid: 1 cycle. Throughput: 1 row/cycle with row_ready held high.
//  gen_count wraps modulo 2^CW only if ngen_q=0 could be used; excluded (ngen==0 -> DONE).
// STRUCTURE
//  Shared package ca_pkg: boundary-mode localparams BM_WRAP=2'b00, BM_ZERO=2'b01,
//   BM_ONE=2'b10; state encoding ST_IDLE/ST_RUN/ST_DONE.
//  Sub-module ca_next_row #(WIDTH): combinational row -> next row given rule_q, bmode_q;
//   one generate loop of 8:1 rule lookups. FSM, counters and handshake in top.
// TESTING (WIDTH=8 bench unless noted)
//  1 rule=90, seed=8'h10, bmode=wrap, ngen=4, ready=1 -> rows 10,28,44,AA on 4
//    consecutive cycles; done one cycle after last beat; gen_count=4.
//  2 rule=90, seed=8'h01, ngen=2, bmode wrap/zero/one -> second row 82 / 02 / 83.
//  3 Backpressure: case 1 with ready toggling 1,0,0,1,... -> row_data stable
//    while ready=0; same 4 rows in order; no beat lost or duplicated.
//  4 ngen=0 start -> no row_valid; done pulses 1 cycle after start; busy stays 0.
//  5 rst_n low mid-run after 2 beats -> outputs 0 asynchronously; restart after
//    seed reload reproduces case 1 from row 10.
//  6 start/seed_load/rule change during RUN -> ignored; sequence as case 1;
//    WIDTH=80 smoke run rule 30 single centre cell, 40 rows vs software model.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared definitions for the cellular-automaton row sequencer: boundary modes,
// FSM state encoding and the boundary-cell helper.
package ca_pkg;

   localparam logic [1:0] BM_WRAP = 2'b00;
   localparam logic [1:0] BM_ZERO = 2'b01;
   localparam logic [1:0] BM_ONE  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Value seen beyond the row edge; mode 2'b11 behaves as wrap.
   function automatic logic boundary_bit(input logic [1:0] bmode, input logic wrap_bit);
      logic b;
      case (bmode)
         BM_ZERO: b = 1'b0;
         BM_ONE:  b = 1'b1;
         default: b = wrap_bit;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ca_next_row.sv
// Combinational next-generation function: each cell looks up the 8-bit rule
// with its {left, self, right} neighbourhood.
module ca_next_row
   import ca_pkg::*;
#(
   parameter int WIDTH = 80
) (
   input  logic [WIDTH-1:0] row,
   input  logic [7:0]       rule,
   input  logic [1:0]       bmode,
   output logic [WIDTH-1:0] nxt
);

   logic left_edge;
   logic right_edge;

   assign left_edge  = boundary_bit(bmode, row[WIDTH-1]);
   assign right_edge = boundary_bit(bmode, row[0]);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic l;
      logic r;
      if (i == 0) begin : g_l_edge
         assign l = left_edge;
      end else begin : g_l_in
         assign l = row[i-1];
      end
      if (i == WIDTH-1) begin : g_r_edge
         assign r = right_edge;
      end else begin : g_r_in
         assign r = row[i+1];
      end
      assign nxt[i] = rule[{l, row[i], r}];
   end

endmodule

// File: rtl/ca_row_sequencer.sv
// Elementary cellular-automaton engine: streams NGEN generations of a WIDTH-cell
// row over a valid/ready interface, starting with the seed row.
//
// state   | meaning
// ST_IDLE | waiting; seed_load and start accepted here only
// ST_RUN  | row_valid high, one generation advanced per accepted beat
// ST_DONE | one-cycle done pulse, then back to idle
module ca_row_sequencer
   import ca_pkg::*;
#(
   parameter int WIDTH = 80,
   parameter int CW    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic [7:0]       rule,
   input  logic [1:0]       bmode,
   input  logic             start,
   input  logic [CW-1:0]    ngen,
   output logic [WIDTH-1:0] row_data,
   output logic             row_valid,
   input  logic             row_ready,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    gen_count
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] row_q, row_d, row_nxt;
   logic [7:0]       rule_q, rule_d;
   logic [1:0]       bmode_q, bmode_d;
   logic [CW-1:0]    ngen_q, ngen_d;
   logic [CW-1:0]    gen_count_q, gen_count_d;
   logic             beat;
   logic             last_beat;

   ca_next_row #(.WIDTH(WIDTH)) u_next_row (
      .row   (row_q),
      .rule  (rule_q),
      .bmode (bmode_q),
      .nxt   (row_nxt)
   );

   // Handshake derived from registered state only, so ready never feeds valid.
   assign beat      = (state_q == ST_RUN) && row_ready;
   assign last_beat = (gen_count_q == ngen_q - CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q       <= '0;
         rule_q      <= '0;
         bmode_q     <= '0;
         ngen_q      <= '0;
         gen_count_q <= '0;
      end else begin
         row_q       <= row_d;
         rule_q      <= rule_d;
         bmode_q     <= bmode_d;
         ngen_q      <= ngen_d;
         gen_count_q <= gen_count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = (ngen == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (beat && last_beat) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Row keeps advancing on the final beat, so a later start continues the sequence.
   always_comb begin
      row_d       = row_q;
      rule_d      = rule_q;
      bmode_d     = bmode_q;
      ngen_d      = ngen_q;
      gen_count_d = gen_count_q;
      case (state_q)
         ST_IDLE: begin
            if (seed_load) begin
               row_d = seed;
            end
            if (start) begin
               rule_d      = rule;
               bmode_d     = bmode;
               ngen_d      = ngen;
               gen_count_d = '0;
            end
         end
         ST_RUN: begin
            if (beat) begin
               row_d       = row_nxt;
               gen_count_d = gen_count_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      row_data  = row_q;
      gen_count = gen_count_q;
      row_valid = (state_q == ST_RUN);
      busy      = (state_q == ST_RUN);
      done      = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_ca_row_sequencer.sv
// Scoreboard bench for ca_row_sequencer: runs are predicted by a software
// automaton and compared beat by beat by an independent monitor.
module tb_ca_row_sequencer;

   localparam int W  = 8;
   localparam int CW = 16;
   localparam int WW = 80;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          seed_load;
   logic [W-1:0]  seed;
   logic [7:0]    rule;
   logic [1:0]    bmode;
   logic          start;
   logic [CW-1:0] ngen;
   logic [W-1:0]  row_data;
   logic          row_valid;
   logic          row_ready;
   logic          busy;
   logic          done;
   logic [CW-1:0] gen_count;

   logic          w_seed_load;
   logic [WW-1:0] w_seed;
   logic [7:0]    w_rule;
   logic [1:0]    w_bmode;
   logic          w_start;
   logic [CW-1:0] w_ngen;
   logic [WW-1:0] w_row_data;
   logic          w_row_valid;
   logic          w_row_ready;
   logic          w_busy;
   logic          w_done;
   logic [CW-1:0] w_gen_count;

   always #5 clk = ~clk;

   ca_row_sequencer #(.WIDTH(W), .CW(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .rule(rule),
      .bmode(bmode), .start(start), .ngen(ngen), .row_data(row_data),
      .row_valid(row_valid), .row_ready(row_ready), .busy(busy), .done(done),
      .gen_count(gen_count)
   );

   ca_row_sequencer #(.WIDTH(WW), .CW(CW)) u_wide (
      .clk(clk), .rst_n(rst_n), .seed_load(w_seed_load), .seed(w_seed), .rule(w_rule),
      .bmode(w_bmode), .start(w_start), .ngen(w_ngen), .row_data(w_row_data),
      .row_valid(w_row_valid), .row_ready(w_row_ready), .busy(w_busy), .done(w_done),
      .gen_count(w_gen_count)
   );

   typedef struct {
      logic [W-1:0]  row;
      logic [CW-1:0] gc;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] log_q[$];
   logic [W-1:0] model_row;
   int           errors = 0;
   int           checks = 0;

   task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference automaton: neighbourhood {L,C,R} read as a number selects a rule bit.
   function automatic logic [WW-1:0] ref_next(input logic [WW-1:0] r, input int w,
                                              input logic [7:0] rl, input logic [1:0] bm);
      logic [WW-1:0] n;
      int l, c, rr, idx, edge_v;
      n = '0;
      for (int i = 0; i < w; i++) begin
         c = int'(r[i]);
         if (bm == 2'b01) edge_v = 0;
         else if (bm == 2'b10) edge_v = 1;
         else edge_v = -1;
         if (i == 0) l = (edge_v < 0) ? int'(r[w-1]) : edge_v;
         else l = int'(r[i-1]);
         if (i == w-1) rr = (edge_v < 0) ? int'(r[0]) : edge_v;
         else rr = int'(r[i+1]);
         idx = l * 4 + c * 2 + rr;
         n[i] = (int'(rl) / (1 << idx)) % 2 == 1;
      end
      return n;
   endfunction

   function automatic logic rdy(input int mode, input int idx);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (idx % 3) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   // Monitor: pops one expectation per accepted beat, checks hold during stalls.
   logic         stall_q = 1'b0;
   logic [W-1:0] stall_data;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            chk("stall_valid_hold", row_valid, 1'b1);
            chk("stall_data_hold", row_data, stall_data);
         end
         stall_q    = row_valid && !row_ready;
         stall_data = row_data;
         if (row_valid && row_ready) begin
            log_q.push_back(row_data);
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", row_data, 'x);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("beat_row", row_data, e.row);
               chk("beat_gen_count", gen_count, e.gc);
            end
         end
      end
   end

   task automatic run(input logic [7:0] rl, input logic [1:0] bm, input int ng,
                      input bit do_seed, input logic [W-1:0] sd, input int rmode,
                      input bit perturb, output int cycles, output bit saw_busy);
      bit got;
      @(posedge clk); #1;
      start = 1'b1; rule = rl; bmode = bm; ngen = CW'(ng);
      seed_load = do_seed; seed = sd; row_ready = 1'b1;
      if (do_seed) model_row = sd;
      for (int k = 0; k < ng; k++) begin
         exp_q.push_back('{row: model_row, gc: CW'(k)});
         model_row = W'(ref_next(WW'(model_row), W, rl, bm));
      end
      cycles = 0; got = 1'b0; saw_busy = 1'b0;
      while (cycles < 300) begin
         @(posedge clk); #1;
         cycles++;
         start = 1'b0; seed_load = 1'b0;
         if (busy) saw_busy = 1'b1;
         if (done) begin
            got = 1'b1;
            break;
         end
         row_ready = rdy(rmode, cycles - 1);
         if (perturb && busy) begin
            start = 1'b1; seed_load = 1'b1; seed = W'($urandom);
            rule = 8'($urandom); bmode = 2'($urandom); ngen = CW'($urandom_range(1, 5));
         end
      end
      start = 1'b0; seed_load = 1'b0;
      chk("done_seen", got, 1'b1);
      if (got) begin
         chk("queue_drained", exp_q.size(), 0);
         chk("gen_count_end", gen_count, ng);
         chk("busy_in_done", busy, 1'b0);
         chk("valid_in_done", row_valid, 1'b0);
         @(posedge clk); #1;
         chk("done_one_cycle", done, 1'b0);
      end
      exp_q.delete();
   endtask

   task automatic chk_log4(input string name, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
      chk({name, "_len"}, log_q.size(), 4);
      if (log_q.size() == 4) begin
         chk({name, "_r0"}, log_q[0], e0);
         chk({name, "_r1"}, log_q[1], e1);
         chk({name, "_r2"}, log_q[2], e2);
         chk({name, "_r3"}, log_q[3], e3);
      end
   endtask

   initial begin
      int cyc;
      bit sb;
      logic [WW-1:0] wm;
      int wk, wc;

      rst_n = 1'b0; seed_load = 0; seed = '0; rule = '0; bmode = '0; start = 0;
      ngen = '0; row_ready = 0; model_row = '0;
      w_seed_load = 0; w_seed = '0; w_rule = '0; w_bmode = '0; w_start = 0;
      w_ngen = '0; w_row_ready = 1'b1;
      #12;
      chk("rst_row_data", row_data, 0);
      chk("rst_valid", row_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_gen_count", gen_count, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Rule 90 from single cell, full throughput
      log_q.delete();
      run(8'd90, 2'b00, 4, 1'b1, 8'h10, 0, 1'b0, cyc, sb);
      chk("c1_cycles", cyc, 5);
      chk_log4("c1", 8'h10, 8'h28, 8'h44, 8'hAA);

      // Boundary modes
      log_q.delete();
      run(8'd90, 2'b00, 2, 1'b1, 8'h01, 0, 1'b0, cyc, sb);
      if (log_q.size() == 2) chk("c2_wrap", log_q[1], 8'h82); else chk("c2_wrap_len", log_q.size(), 2);
      log_q.delete();
      run(8'd90, 2'b01, 2, 1'b1, 8'h01, 0, 1'b0, cyc, sb);
      if (log_q.size() == 2) chk("c2_zero", log_q[1], 8'h02); else chk("c2_zero_len", log_q.size(), 2);
      log_q.delete();
      run(8'd90, 2'b10, 2, 1'b1, 8'h01, 0, 1'b0, cyc, sb);
      if (log_q.size() == 2) chk("c2_one", log_q[1], 8'h83); else chk("c2_one_len", log_q.size(), 2);

      // Backpressure 1,0,0,1,...
      log_q.delete();
      run(8'd90, 2'b00, 4, 1'b1, 8'h10, 1, 1'b0, cyc, sb);
      chk_log4("c3", 8'h10, 8'h28, 8'h44, 8'hAA);

      // Zero-length run
      log_q.delete();
      run(8'd90, 2'b00, 0, 1'b0, 8'h00, 0, 1'b0, cyc, sb);
      chk("c4_cycles", cyc, 1);
      chk("c4_no_busy", sb, 1'b0);
      chk("c4_no_rows", log_q.size(), 0);

      // Reset mid-run after two beats
      @(posedge clk); #1;
      start = 1'b1; seed_load = 1'b1; seed = 8'h10; rule = 8'd90; bmode = 2'b00;
      ngen = CW'(4); row_ready = 1'b1;
      exp_q.push_back('{row: 8'h10, gc: CW'(0)});
      exp_q.push_back('{row: 8'h28, gc: CW'(1)});
      exp_q.push_back('{row: 8'h44, gc: CW'(2)});
      exp_q.push_back('{row: 8'hAA, gc: CW'(3)});
      @(posedge clk); #1; start = 1'b0; seed_load = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("c5_pre_gen_count", gen_count, 2);
      rst_n = 1'b0;
      #1;
      chk("c5_async_valid", row_valid, 0);
      chk("c5_async_busy", busy, 0);
      chk("c5_async_row", row_data, 0);
      chk("c5_async_gen_count", gen_count, 0);
      chk("c5_async_done", done, 0);
      exp_q.delete();
      model_row = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("c5_no_done_after_reset", done, 0);
      log_q.delete();
      run(8'd90, 2'b00, 4, 1'b1, 8'h10, 0, 1'b0, cyc, sb);
      chk_log4("c5", 8'h10, 8'h28, 8'h44, 8'hAA);

      // Inputs toggled during RUN must not disturb the run
      log_q.delete();
      run(8'd90, 2'b00, 4, 1'b1, 8'h10, 0, 1'b1, cyc, sb);
      chk_log4("c6", 8'h10, 8'h28, 8'h44, 8'hAA);
      log_q.delete();
      run(8'd90, 2'b00, 4, 1'b1, 8'h10, 2, 1'b1, cyc, sb);
      chk_log4("c6_bp", 8'h10, 8'h28, 8'h44, 8'hAA);

      // Random runs; unseeded runs continue from where the row left off
      for (int n = 0; n < 14; n++) begin
         run(8'($urandom), 2'($urandom), $urandom_range(1, 10), 1'($urandom_range(0, 1)),
             W'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), cyc, sb);
      end

      // Wide smoke: rule 30 from a single centre cell
      wm = '0; wm[40] = 1'b1;
      @(posedge clk); #1;
      w_seed = wm; w_seed_load = 1'b1; w_rule = 8'd30; w_bmode = 2'b00;
      w_ngen = CW'(40); w_start = 1'b1; w_row_ready = 1'b1;
      @(posedge clk); #1;
      w_seed_load = 1'b0; w_start = 1'b0;
      wk = 0; wc = 0;
      while (wc < 100 && !w_done) begin
         @(negedge clk);
         wc++;
         if (w_row_valid) begin
            if (w_row_data !== wm) chk("wide_row", w_row_data, wm);
            else checks++;
            wm = ref_next(wm, WW, 8'd30, 2'b00);
            wk++;
         end
      end
      chk("wide_done_seen", w_done, 1'b1);
      chk("wide_rows", wk, 40);
      chk("wide_gen_count", w_gen_count, 40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
